// File: rtl/spi_burst_feeder.sv
// rtl/spi_burst_feeder.sv - buffered burst command/data front-end for the SPI master parallel port
module spi_burst_feeder #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DWIDTH-1:0] cmd_addr,
    input  logic [15:0]       cmd_len,
    input  logic [7:0]        cmd_div,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DWIDTH-1:0] wr_word,
    output logic              rd_valid,
    output logic [DWIDTH-1:0] rd_word,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic [DWIDTH-1:0] m_addr,
    output logic [DWIDTH-1:0] m_wr_data,
    output logic [15:0]       m_NoD,
    output logic [7:0]        m_SCK_div,
    output logic              m_start,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic              m_spi_done,
    input  logic [2:0]        m_state,
    input  logic [DWIDTH-1:0] m_rd_data
);
    typedef enum logic [2:0] {F_IDLE, F_WAIT, F_START, F_RUN, F_DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [15:0] DEPTH_L = 16'(DEPTH);
    localparam logic [2:0]  ST_DATA = 3'b011;

    state_t            state, state_nxt;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr, rptr;
    logic [AW:0]       count;
    logic [15:0]       count_ext;
    logic [15:0]       wcnt;
    logic              cap_pend;
    logic [DWIDTH-1:0] rd_last;
    logic              ws, ws_run, push, pop;
    logic              accept, len_zero, len_big, launch;

    assign ws        = m_spi_done && (m_state == ST_DATA);
    assign ws_run    = ws && (state == F_RUN);
    assign wr_ready  = (count < DEPTH_C);
    assign push      = wr_valid && wr_ready;
    // Never pop past the burst length or from an empty FIFO, even if the master misbehaves.
    assign pop       = ws_run && (wcnt < m_NoD) && (count != '0);
    assign m_wr_data = (count == '0) ? '0 : mem[rptr];
    assign count_ext = 16'(count);

    assign cmd_ready = (state == F_IDLE);
    assign accept    = cmd_ready && cmd_valid;
    assign len_zero  = (cmd_len == 16'd0);
    assign len_big   = (cmd_len > DEPTH_L);
    assign launch    = accept && !len_zero && !len_big;

    // The master updates rd_data on the strobe edge, so the reply is forwarded straight through.
    assign rd_valid  = cap_pend;
    assign rd_word   = cap_pend ? m_rd_data : rd_last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_word;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE:  if (launch) state_nxt = F_WAIT;
            F_WAIT:  if ((count_ext >= m_NoD) && !m_busy) state_nxt = F_START;
            F_START: state_nxt = F_RUN;
            F_RUN:   if (m_done) state_nxt = F_DONE;
            F_DONE:  state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state     <= F_IDLE;
            m_start   <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            cap_pend  <= 1'b0;
            rd_last   <= '0;
            m_addr    <= '0;
            m_NoD     <= '0;
            m_SCK_div <= '0;
            wcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
        end else begin
            state    <= state_nxt;
            m_start  <= (state == F_START);
            cmd_done <= (accept && len_zero) || ((state == F_RUN) && m_done);
            cmd_err  <= accept && len_big;
            cap_pend <= ws_run;
            if (cap_pend) begin
                rd_last <= m_rd_data;
            end
            if (launch) begin
                m_addr    <= cmd_addr;
                m_NoD     <= cmd_len;
                m_SCK_div <= cmd_div;
                wcnt      <= '0;
            end else if (pop) begin
                wcnt <= wcnt + 16'd1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_feeder.sv
// tb/tb_spi_burst_feeder.sv - self-checking bench for spi_burst_feeder with a behavioural SPI master
`timescale 1ns/1ps
module tb_spi_burst_feeder;
    localparam int DEPTH = 16;
    localparam logic [2:0] ST_DATA = 3'b011;

    logic        clk = 1'b0;
    logic        Rst;
    logic        cmd_valid, cmd_ready, wr_valid, wr_ready, rd_valid, cmd_done, cmd_err;
    logic [15:0] cmd_addr, cmd_len, wr_word, rd_word, m_addr, m_wr_data, m_NoD, m_rd_data;
    logic [7:0]  cmd_div, m_SCK_div;
    logic        m_start, m_busy, m_done, m_spi_done;
    logic [2:0]  m_state;

    spi_burst_feeder dut (
        .clk(clk), .Rst(Rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_div(cmd_div),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_word(wr_word),
        .rd_valid(rd_valid), .rd_word(rd_word), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .m_NoD(m_NoD), .m_SCK_div(m_SCK_div),
        .m_start(m_start), .m_busy(m_busy), .m_done(m_done), .m_spi_done(m_spi_done),
        .m_state(m_state), .m_rd_data(m_rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          start_cnt = 0;
    logic [15:0] last_reply = '0;
    logic [15:0] mosi_q[$];
    int          rd_cnt = 0;
    logic [15:0] sent_arr [512];
    int          sent_n = 0;
    int          consumed = 0;
    logic [15:0] model_q[$];
    logic        prev_ws = 1'b0, prev_mdone = 1'b0, prev_len0 = 1'b0, prev_big = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mtick(inout logic ab);
        @(posedge clk); #1;
        if (Rst) ab = 1'b1;
    endtask

    // Behavioural SPI master: address word, then NoD data words, one strobe per word.
    initial begin
        m_busy = 0; m_done = 0; m_spi_done = 0; m_state = 3'b000; m_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!Rst && m_start) begin : burst
                int nod;
                int div;
                logic ab;
                logic [15:0] rep;
                start_cnt++;
                mosi_q.delete();
                nod = int'(m_NoD);
                div = int'(m_SCK_div);
                ab = 1'b0;
                mtick(ab);
                m_busy = 1; m_state = 3'b010;
                for (int c = 0; c <= div && !ab; c++) mtick(ab);
                if (!ab) begin
                    mosi_q.push_back(m_addr);
                    m_spi_done = 1; mtick(ab); m_spi_done = 0;
                end
                for (int w = 0; w < nod && !ab; w++) begin
                    m_state = ST_DATA;
                    mosi_q.push_back(m_wr_data);
                    for (int c = 0; c < div && !ab; c++) mtick(ab);
                    if (!ab) begin
                        m_spi_done = 1; mtick(ab); m_spi_done = 0;
                        rep = 16'($urandom);
                        m_rd_data = rep;
                        last_reply = rep;
                    end
                end
                if (!ab) begin
                    m_state = 3'b100; m_done = 1; mtick(ab); m_done = 0;
                end
                m_busy = 0; m_state = 3'b000; m_spi_done = 0;
            end
        end
    end

    // Reference model: FIFO as a queue, pulses derived from the previous cycle's events.
    always @(negedge clk) begin
        logic ws;
        if (Rst) begin
            model_q.delete();
            prev_ws = 0; prev_mdone = 0; prev_len0 = 0; prev_big = 0;
        end else begin
            check("wr_ready", wr_ready, model_q.size() < DEPTH);
            check("m_wr_data", m_wr_data, (model_q.size() > 0) ? model_q[0] : 16'h0);
            check("rd_valid", rd_valid, prev_ws);
            if (rd_valid) begin
                check("rd_word", rd_word, last_reply);
                rd_cnt++;
            end
            check("cmd_done", cmd_done, prev_mdone || prev_len0);
            check("cmd_err", cmd_err, prev_big);
            check("start_vs_busy", m_start && m_busy, 0);
            ws = m_spi_done && (m_state == ST_DATA);
            if (wr_valid && model_q.size() < DEPTH) begin
                model_q.push_back(wr_word);
                sent_arr[sent_n] = wr_word;
                sent_n++;
            end
            if (ws && model_q.size() > 0) void'(model_q.pop_front());
            prev_ws    = ws;
            prev_mdone = m_done;
            prev_len0  = cmd_valid && (cmd_len == 16'd0);
            prev_big   = cmd_valid && (cmd_len > 16'(DEPTH));
        end
    end

    task automatic push_word(input logic [15:0] w);
        int n;
        n = 0;
        wr_valid = 1; wr_word = w;
        while (!wr_ready && n < 300) begin tick(); n++; end
        check("push_accept", n < 300, 1);
        tick();
        wr_valid = 0;
    endtask

    task automatic issue_cmd(input logic [15:0] a, input logic [15:0] l, input logic [7:0] d);
        int n;
        n = 0;
        while (!cmd_ready && n < 300) begin tick(); n++; end
        check("cmd_ready_wait", n < 300, 1);
        cmd_valid = 1; cmd_addr = a; cmd_len = l; cmd_div = d;
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_result(output logic got_done, output logic got_err);
        got_done = 0; got_err = 0;
        for (int n = 0; n < 3000; n++) begin
            if (cmd_done) begin got_done = 1; break; end
            if (cmd_err) begin got_err = 1; break; end
            tick();
        end
    endtask

    task automatic check_mosi(input logic [15:0] a, input int len);
        check("mosi_len", mosi_q.size(), len + 1);
        if (mosi_q.size() == len + 1) begin
            check("mosi_addr", mosi_q[0], a);
            for (int i = 0; i < len; i++) check("mosi_word", mosi_q[i+1], sent_arr[consumed+i]);
        end
        consumed += len;
    endtask

    task automatic check_reset_outputs();
        check("rst_m_start", m_start, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_word", rd_word, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_NoD", m_NoD, 0);
        check("rst_m_SCK_div", m_SCK_div, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_fifo_empty", m_wr_data, 0);
    endtask

    task automatic run_cmd(input logic [15:0] a, input int len, input int div, input int npush,
                           input logic [15:0] w0, input logic cmd_first,
                           input logic exp_done, input logic exp_err);
        int s0, r0;
        logic d, e, burst;
        s0 = start_cnt; r0 = rd_cnt;
        burst = (len >= 1) && (len <= DEPTH);
        if (cmd_first) issue_cmd(a, 16'(len), 8'(div));
        for (int i = 0; i < npush; i++) push_word((i == 0) ? w0 : 16'($urandom));
        if (!cmd_first) issue_cmd(a, 16'(len), 8'(div));
        wait_result(d, e);
        check("done_seen", d, exp_done);
        check("err_seen", e, exp_err);
        if (d && burst) begin
            check("ready_in_done", cmd_ready, 0);
            tick();
            check("ready_after_done", cmd_ready, 1);
        end
        repeat (2) tick();
        check("start_pulses", start_cnt - s0, burst ? 1 : 0);
        check("rd_pulses", rd_cnt - r0, burst ? len : 0);
        if (burst) check_mosi(a, len);
    endtask

    typedef struct {
        logic [15:0] addr;
        int          len;
        int          div;
        int          npush;
        logic [15:0] w0;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vecs[9];
        int pushed, s0, n;
        logic d, e;

        vecs[0] = '{16'h0012,  1, 0, 1, 16'hA5A5, 1'b1, 1'b0};
        vecs[1] = '{16'h1234,  3, 1, 3, 16'h0F00, 1'b1, 1'b0};
        vecs[2] = '{16'h0F0F,  2, 2, 5, 16'hC3C3, 1'b1, 1'b0};
        vecs[3] = '{16'h7777,  3, 0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h5555,  0, 0, 0, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{16'hDEAD, 17, 0, 0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{16'h0101,  5, 7, 5, 16'h8001, 1'b1, 1'b0};
        vecs[7] = '{16'h00AA,  2, 3, 4, 16'h7E7E, 1'b1, 1'b0};
        vecs[8] = '{16'h0BB0,  2, 0, 0, 16'h0000, 1'b1, 1'b0};

        Rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_div = '0;
        wr_valid = 0; wr_word = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        Rst = 0;
        tick();

        for (int i = 0; i < 9; i++)
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].div, vecs[i].npush, vecs[i].w0,
                    1'b0, vecs[i].exp_done, vecs[i].exp_err);

        for (int i = 0; i < 6; i++) begin
            int l;
            l = $urandom_range(1, 8);
            run_cmd(16'($urandom), l, $urandom_range(0, 3), l, 16'($urandom),
                    1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        // Command before data: no launch until the last word is buffered.
        s0 = start_cnt;
        issue_cmd(16'h0C0C, 16'd4, 8'd3);
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
        repeat (8) tick();
        check("no_early_start", start_cnt - s0, 0);
        push_word(16'h4444);
        wait_result(d, e);
        check("b4_done", d, 1);
        repeat (2) tick();
        check_mosi(16'h0C0C, 4);

        // Full FIFO: the 17th word waits for the first pop of a len=16 burst.
        pushed = 0;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    push_word(16'h0100 + 16'(i));
                    pushed++;
                end
            end
            begin
                n = 0;
                while (pushed < 16 && n < 500) begin tick(); n++; end
                repeat (5) tick();
                check("full_wr_ready", wr_ready, 0);
                check("full_accepted", pushed, 16);
                issue_cmd(16'h00F0, 16'd16, 8'd0);
                wait_result(d, e);
                check("full_done", d, 1);
            end
        join
        repeat (2) tick();
        check_mosi(16'h00F0, 16);
        run_cmd(16'h00F1, 1, 0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a len=4 burst.
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) push_word(16'($urandom));
        issue_cmd(16'h0404, 16'd4, 8'd3);
        n = 0;
        while (!(start_cnt > s0 && mosi_q.size() >= 3) && n < 500) begin tick(); n++; end
        check("reached_word2", n < 500, 1);
        #2;
        Rst = 1;
        #1;
        check_reset_outputs();
        repeat (2) tick();
        Rst = 0;
        consumed = sent_n;
        d = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_done) d = 1;
        end
        check("no_done_after_reset", d, 0);
        check("fifo_empty_after_reset", m_wr_data, 0);
        run_cmd(16'h0505, 1, 1, 1, 16'h5A5A, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
